// File: rtl/out_display.sv
// Output register stage: latches the bus byte, converts it to decimal by sequential
// double-dabble and scans the result onto a 4-digit common-anode 7-segment display.
module out_display #(
   parameter int SCAN_DIV = 1024
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic [7:0] bus_in,
   input  logic       oi_n,
   input  logic       signed_mode,
   output logic [7:0] out_value,
   output logic       busy,
   output logic [6:0] seg_n,
   output logic [3:0] an_n
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_COMMIT
   } state_t;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] c;
      case (d)
         4'd0:    c = 7'b1000000;
         4'd1:    c = 7'b1111001;
         4'd2:    c = 7'b0100100;
         4'd3:    c = 7'b0110000;
         4'd4:    c = 7'b0011001;
         4'd5:    c = 7'b0010010;
         4'd6:    c = 7'b0000010;
         4'd7:    c = 7'b1111000;
         4'd8:    c = 7'b0000000;
         4'd9:    c = 7'b0010000;
         default: c = SEG_BLANK;
      endcase
      return c;
   endfunction

   // Two's-complement magnitude; a 9-bit signed view keeps -128 representable as 128.
   function automatic logic [7:0] magnitude(input logic neg, input logic [7:0] b);
      logic signed [8:0] sv;
      logic signed [8:0] av;
      sv = neg ? $signed({b[7], b}) : $signed({1'b0, b});
      av = (sv < 0) ? -sv : sv;
      return av[7:0];
   endfunction

   function automatic logic [11:0] bcd_add3(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int i = 0; i < 3; i++) begin
         if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [3:0][6:0] compose(input logic neg, input logic [11:0] b);
      logic [3:0][6:0] d;
      d[3] = neg ? SEG_DASH : SEG_BLANK;
      d[2] = (b[11:8] != 4'd0) ? seg_code(b[11:8]) : SEG_BLANK;
      d[1] = (b[11:4] != 8'd0) ? seg_code(b[7:4]) : SEG_BLANK;
      d[0] = seg_code(b[3:0]);
      return d;
   endfunction

   state_t           state_q;
   logic             busy_q;
   logic [7:0]       out_value_q;
   logic             sgn_q;
   logic [7:0]       mag_q;
   logic [11:0]      bcd_q;
   logic [2:0]       bit_q;
   logic [3:0][6:0]  disp_q;
   logic [3:0][6:0]  disp_d;
   logic [CNT_W-1:0] scan_q;
   logic [CNT_W-1:0] scan_d;
   logic [1:0]       idx_q;
   logic [1:0]       idx_d;
   logic [3:0]       an_n_q;
   logic [3:0]       an_n_d;
   logic [6:0]       seg_n_q;
   logic [6:0]       seg_n_d;

   // A load on the commit edge wins, so the aborted result never reaches the display.
   always_comb begin
      disp_d = disp_q;
      if (oi_n && state_q == S_COMMIT) disp_d = compose(sgn_q, bcd_q);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         out_value_q <= 8'd0;
         sgn_q       <= 1'b0;
         mag_q       <= 8'd0;
         bcd_q       <= 12'd0;
         bit_q       <= 3'd0;
         disp_q      <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO};
      end else begin
         disp_q <= disp_d;
         if (!oi_n) begin
            out_value_q <= bus_in;
            sgn_q       <= signed_mode & bus_in[7];
            mag_q       <= magnitude(signed_mode & bus_in[7], bus_in);
            bcd_q       <= 12'd0;
            bit_q       <= 3'd0;
            busy_q      <= 1'b1;
            state_q     <= S_CONV;
         end else begin
            case (state_q)
               S_CONV: begin
                  {bcd_q, mag_q} <= {bcd_add3(bcd_q), mag_q} << 1;
                  bit_q          <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= S_COMMIT;
               end
               S_COMMIT: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Scan outputs come from the next-state digit so anode and segments always move together.
   always_comb begin
      scan_d  = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
      idx_d   = (scan_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
      an_n_d  = ~(4'b0001 << idx_d);
      seg_n_d = disp_d[idx_d];
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         scan_q  <= '0;
         idx_q   <= 2'd0;
         an_n_q  <= 4'b1110;
         seg_n_q <= SEG_ZERO;
      end else begin
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         an_n_q  <= an_n_d;
         seg_n_q <= seg_n_d;
      end
   end

   assign out_value = out_value_q;
   assign busy      = busy_q;
   assign seg_n     = seg_n_q;
   assign an_n      = an_n_q;

endmodule

// File: tb/tb_out_display.sv
// Scoreboard bench for out_display: stimulus queues expected conversions, a monitor
// checks busy timing, latched value and the scanned display every cycle.
module tb_out_display;
   localparam int SD = 4;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] SEGTAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic [7:0] bus_in = 8'd0;
   logic       oi_n = 1'b1;
   logic       signed_mode = 1'b0;
   logic [7:0] out_value;
   logic       busy;
   logic [6:0] seg_n;
   logic [3:0] an_n;

   out_display #(.SCAN_DIV(SD)) dut (
      .clk(clk), .clr_n(clr_n), .bus_in(bus_in), .oi_n(oi_n), .signed_mode(signed_mode),
      .out_value(out_value), .busy(busy), .seg_n(seg_n), .an_n(an_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              fall;
      logic [7:0]      val;
      logic [3:0][6:0] disp;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;
   int   cyc = 0;
   int   edges = 0;
   int   last_fall = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Decimal reference computed directly from the byte value.
   function automatic logic [3:0][6:0] ref_disp(input logic [7:0] b, input logic s);
      logic [3:0][6:0] d;
      int v, a, h, t, o;
      v = (s && b[7]) ? int'(b) - 256 : int'(b);
      a = (v < 0) ? -v : v;
      h = a / 100;
      t = (a / 10) % 10;
      o = a % 10;
      d[3] = (v < 0) ? DASH : BLANK;
      d[2] = (h != 0) ? SEGTAB[h] : BLANK;
      d[1] = (h != 0 || t != 0) ? SEGTAB[t] : BLANK;
      d[0] = SEGTAB[o];
      return d;
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!clr_n) edges = 0;
      else edges = edges + 1;
   end

   logic            prev_busy = 1'b0;
   logic [3:0][6:0] exp_disp = {BLANK, BLANK, BLANK, 7'b1000000};

   always @(negedge clk) begin
      exp_t       e;
      int         idx;
      logic [3:0] ea;
      if (!clr_n) begin
         exp_disp  = {BLANK, BLANK, BLANK, SEGTAB[0]};
         prev_busy = 1'b0;
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_out_value", {24'd0, out_value}, 32'd0);
      end else begin
         if (prev_busy && !busy) begin
            if (q.size() == 0) begin
               check("unexpected_busy_fall", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("busy_fall_cycle", cyc, e.fall);
               check("out_value", {24'd0, out_value}, {24'd0, e.val});
               exp_disp = e.disp;
            end
         end else if (q.size() > 0 && cyc > q[0].fall) begin
            e = q.pop_front();
            check("busy_timeout", cyc, e.fall);
            exp_disp = e.disp;
         end
         prev_busy = busy;
      end
      idx = clr_n ? (edges / SD) % 4 : 0;
      ea  = ~(4'b0001 << idx);
      check("an_n", {28'd0, an_n}, {28'd0, ea});
      check("seg_n", {25'd0, seg_n}, {25'd0, exp_disp[idx]});
   end

   task automatic do_load(input logic [7:0] b, input logic s, input int hold);
      exp_t e;
      int   first;
      @(negedge clk);
      bus_in = b;
      signed_mode = s;
      oi_n = 1'b0;
      repeat (hold) @(negedge clk);
      oi_n = 1'b1;
      bus_in = 8'($urandom);
      signed_mode = 1'($urandom);
      first = cyc - hold + 1;
      e.fall = cyc + 9;
      e.val  = b;
      e.disp = ref_disp(b, s);
      if (q.size() > 0 && first < last_fall) void'(q.pop_back());
      q.push_back(e);
      last_fall = cyc + 9;
      check("out_after_load", {24'd0, out_value}, {24'd0, b});
   endtask

   task automatic wait_idle();
      while (cyc < last_fall + 1) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      #2 clr_n = 1'b1;
      repeat (24) @(negedge clk);

      do_load(8'hFF, 1'b0, 1); wait_idle(); repeat (18) @(negedge clk);
      do_load(8'hFC, 1'b1, 1); wait_idle(); repeat (18) @(negedge clk);
      do_load(8'h80, 1'b1, 1); wait_idle(); repeat (18) @(negedge clk);
      do_load(8'h80, 1'b0, 1); wait_idle(); repeat (18) @(negedge clk);

      do_load(8'h05, 1'b0, 1);
      @(negedge clk);
      do_load(8'h07, 1'b0, 1);
      wait_idle(); repeat (18) @(negedge clk);

      do_load(8'h2A, 1'b1, 6); wait_idle(); repeat (18) @(negedge clk);

      do_load(8'h99, 1'b0, 1);
      repeat (3) @(negedge clk);
      #2 clr_n = 1'b0;
      q.delete();
      last_fall = 0;
      @(negedge clk);
      @(negedge clk);
      #2 clr_n = 1'b1;
      repeat (3) @(negedge clk);
      do_load(8'h0A, 1'b0, 1); wait_idle(); repeat (18) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            do_load(8'($urandom), 1'($urandom), 1);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_load(8'($urandom), 1'($urandom), 1);
         end else begin
            do_load(8'($urandom), 1'($urandom), 1);
         end
         wait_idle();
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end

      wait_idle();
      repeat (20) @(negedge clk);
      check("queue_drained", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/out_display.md
Name: out_display

Overview:
- Output register stage sitting on the bus downstream of the ALU.
- Latches a bus byte on an active-low load strobe, as the ALU result is driven onto the bus.
- Converts the byte to decimal with sequential double-dabble, in unsigned or two's-complement mode.
- Drives a 4-digit multiplexed common-anode 7-segment display.

Parameters:
SCAN_DIV, 1024, clocks each digit stays lit before the scan advances (>=2)

Ports:
clk  input  1  system clock, rising edge
clr_n  input  1  asynchronous active-low reset
bus_in  input  8  data bus
oi_n  input  1  output-register load, active low, sampled at rising clk
signed_mode  input  1  1 = interpret byte as two's complement; sampled only at load
out_value  output  8  latched byte
busy  output  1  conversion in progress
seg_n  output  7  segments {g,f,e,d,c,b,a}, active low
an_n  output  4  digit enables, active low, one-hot; an_n[0] = rightmost digit

Behaviour:
- Clocking and reset: one clock domain. clr_n is asynchronous and active-low. While clr_n=0, all state is forced to reset values immediately, including mid-conversion and mid-scan.
- Reset values:
  - out_value=0, busy=0, FSM=IDLE, scan counter=0, digit index=0.
  - Committed display is "   0": digit0 = '0', digits 3..1 blank.
  - Therefore an_n=4'b1110 and seg_n=7'b1000000.
- Load: on a rising edge with oi_n=0 (edge N):
  - out_value <= bus_in.
  - sgn <= signed_mode & bus_in[7].
  - mag <= sgn ? (~bus_in + 1) : bus_in. Computed 8-bit; 0x80 yields 128.
  - FSM -> CONV, bit counter=0, BCD scratch=0.
  - A load while busy aborts and restarts the conversion with the new byte.
  - The committed display is untouched until the new conversion finishes.
- FSM IDLE: busy=0; waits for load.
- FSM CONV: busy=1. One double-dabble iteration per clock, 8 iterations on edges N+1..N+8:
  - add 3 to any BCD nibble >=5;
  - then shift {bcd, mag} left by 1.
  - After the 8th iteration -> COMMIT.
- FSM COMMIT (edge N+9):
  - Display registers <= {sign, hundreds, tens, ones}.
  - busy <= 0; FSM -> IDLE.
  - busy is high exactly 9 clock cycles after the load edge.
- Display composition:
  - digit3 = '-' if sgn, else blank.
  - digit2 = hundreds, blank if 0.
  - digit1 = tens, blank if hundreds=0 and tens=0.
  - digit0 = ones, always shown.
- Segment codes (gfedcba, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - '-'=0111111, blank=1111111
- Scan:
  - Free-running counter 0..SCAN_DIV-1, independent of FSM/load.
  - On wrap, digit index increments 0->1->2->3->0.
  - an_n = ~(1<<index). seg_n = code of committed digit[index], registered together with an_n so the pair never mismatches.
- signed_mode changes without a load have no effect.
- oi_n held low continuously restarts every cycle. busy stays 1 and the display does not update until oi_n is released.

Test Plan:
1. clr_n=0 then release, no load -> out_value=0x00, busy=0, an_n=1110 with seg_n=1000000; other digits show 1111111.
2. SCAN_DIV=4, bench observes 20 clocks -> an_n sequence 1110,1101,1011,0111,1110, each held 4 clocks, wrapping without gaps.
3. Load 0xFF with signed_mode=0:
   - out_value=0xFF the cycle after the load edge.
   - busy=1 for exactly 9 cycles.
   - Then digits3..0 = blank,'2','5','5' (1111111,0100100,0010010,0010010).
4. Load 0xFC signed_mode=1 -> '-',blank,blank,'4'. Load 0x80 signed_mode=1 -> '-','1','2','8'. Load 0x80 signed_mode=0 -> blank,'1','2','8'.
5. Load 0x05, then load 0x07 three cycles later:
   - busy stays high until 9 cycles after the second load.
   - Display goes straight from the previous value to blank,blank,blank,'7'; '5' is never shown.
6. Load 0x99 (153), assert clr_n=0 at cycle 4 of the conversion:
   - busy=0, out_value=0, display "   0" immediately.
   - After release and a fresh load of 0x0A -> blank,blank,'1','0'.
